// File: rtl/booth_multiplier_seq_if.sv
// booth_multiplier_seq_if: start/operand/result bundle for the sequential Booth multiplier
interface booth_multiplier_seq_if #(parameter int WIDTH = 8);
  logic                 start;
  logic [WIDTH-1:0]     M;
  logic [WIDTH-1:0]     Q;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic                 done;
  modport master (output start, M, Q, input product, busy, done);
  modport slave  (input start, M, Q, output product, busy, done);
endinterface

// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq: radix-2 Booth signed multiplier, one add/sub-and-shift step per clock
module booth_multiplier_seq #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  booth_multiplier_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t               state_q, state_d;
  logic [WIDTH:0]       a_q, a_d, m_q, m_d, sum;
  logic [WIDTH-1:0]     qr_q, qr_d;
  logic                 q1_q, q1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [2*WIDTH+1:0]   shifted;
  assign bus.product = product_q;
  assign bus.busy    = state_q != IDLE;
  assign bus.done    = state_q == DONE;
  // state, datapath and result registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      m_q       <= '0;
      qr_q      <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      qr_q      <= qr_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end
  // Booth step on {Q[0], Q_-1}, then arithmetic shift of {A, Q, Q_-1}; A is one bit wider so -2^(W-1) never overflows
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    qr_d      = qr_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    sum       = (qr_q[0] && !q1_q) ? a_q - m_q : (!qr_q[0] && q1_q) ? a_q + m_q : a_q;
    shifted   = {sum[WIDTH], sum, qr_q};
    if (state_q == IDLE && bus.start) begin
      state_d = RUN;
      m_d     = {bus.M[WIDTH-1], bus.M};
      qr_d    = bus.Q;
      a_d     = '0;
      q1_d    = 1'b0;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d   = shifted[2*WIDTH+1:WIDTH+1];
      qr_d  = shifted[WIDTH:1];
      q1_d  = shifted[0];
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d   = DONE;
        product_d = shifted[2*WIDTH:1];
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
endmodule

// File: tb/tb_booth_multiplier_seq.sv
// tb_booth_multiplier_seq: directed and random checks of the Booth multiplier against signed arithmetic
module tb_booth_multiplier_seq;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  booth_multiplier_seq_if #(.WIDTH(8)) b8();
  booth_multiplier_seq_if #(.WIDTH(4)) b4();
  booth_multiplier_seq #(.WIDTH(8)) dut8 (.clk(clk), .n_rst(n_rst), .bus(b8.slave));
  booth_multiplier_seq #(.WIDTH(4)) dut4 (.clk(clk), .n_rst(n_rst), .bus(b4.slave));
  function automatic logic [15:0] model8(input logic signed [7:0] m, input logic signed [7:0] q);
    logic signed [15:0] r;
    r = m * q;
    return r;
  endfunction
  function automatic logic [7:0] model4(input logic signed [3:0] m, input logic signed [3:0] q);
    logic signed [7:0] r;
    r = m * q;
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic go8(input string tag, input logic [7:0] m, input logic [7:0] q);
    int bc, lat, dn;
    @(negedge clk);
    b8.start = 1'b1; b8.M = m; b8.Q = q;
    @(negedge clk);
    b8.start = 1'b0; b8.M = ~m; b8.Q = ~q;
    bc = 0; lat = -1; dn = 0;
    for (int k = 0; k < 40; k++) begin
      if (b8.done) begin dn++; lat = k; end
      if (!b8.busy) break;
      bc++;
      @(negedge clk);
    end
    chk({tag, "_product"}, 32'(b8.product), 32'(model8(m, q)));
    chk({tag, "_latency"}, 32'(lat), 32'd8);
    chk({tag, "_busy_cycles"}, 32'(bc), 32'd9);
    chk({tag, "_done_pulses"}, 32'(dn), 32'd1);
  endtask
  task automatic go4(input logic [3:0] m, input logic [3:0] q);
    @(negedge clk);
    b4.start = 1'b1; b4.M = m; b4.Q = q;
    @(negedge clk);
    b4.start = 1'b0;
    for (int k = 0; k < 20 && !b4.done; k++) @(negedge clk);
    chk("w4_sweep", {23'd0, b4.done, b4.product}, {23'd0, 1'b1, model4(m, q)});
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] mh [40];
    logic [7:0] qh [40];
    int dn, last;
    b8.start = 1'b0; b8.M = '0; b8.Q = '0;
    b4.start = 1'b0; b4.M = '0; b4.Q = '0;
    repeat (2) @(negedge clk);
    chk("rst_product", 32'(b8.product), 32'd0);
    chk("rst_busy", 32'(b8.busy), 32'd0);
    chk("rst_done", 32'(b8.done), 32'd0);
    n_rst = 1'b1;
    go8("t1_7x-3", 8'd7, 8'hFD);
    chk("t1_const", 32'(b8.product), 32'hFFEB);
    go8("t2_min_min", 8'h80, 8'h80);
    chk("t2_const_4000", 32'(b8.product), 32'h4000);
    go8("t2_max_max", 8'h7F, 8'h7F);
    chk("t2_const_3F01", 32'(b8.product), 32'h3F01);
    go8("t2_min_max", 8'h80, 8'h7F);
    chk("t2_const_C080", 32'(b8.product), 32'hC080);
    go8("t3_zero", 8'h00, 8'hFF);
    chk("t3_const_0", 32'(b8.product), 32'h0000);
    go8("t3_m1m1", 8'hFF, 8'hFF);
    chk("t3_const_1", 32'(b8.product), 32'h0001);
    for (int i = 0; i < 12; i++) go8("rand", 8'($urandom), 8'($urandom));
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) go4(4'(i), 4'(j));
    @(negedge clk);
    b8.start = 1'b1; b8.M = 8'd5; b8.Q = 8'd6;
    @(negedge clk);
    b8.start = 1'b0;
    repeat (2) @(negedge clk);
    b8.start = 1'b1; b8.M = 8'd1; b8.Q = 8'd1;
    @(negedge clk);
    b8.start = 1'b0;
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      if (b8.done) dn++;
      @(negedge clk);
    end
    chk("t4_product", 32'(b8.product), 32'd30);
    chk("t4_done_pulses", 32'(dn), 32'd1);
    @(negedge clk);
    b8.start = 1'b1; b8.M = 8'd9; b8.Q = 8'd9;
    @(negedge clk);
    b8.start = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("t5_rst_product", 32'(b8.product), 32'd0);
    chk("t5_rst_busy", 32'(b8.busy), 32'd0);
    chk("t5_rst_done", 32'(b8.done), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      if (b8.done) dn++;
      @(negedge clk);
    end
    chk("t5_no_done", 32'(dn), 32'd0);
    go8("t5_after", 8'd2, 8'd3);
    dn = 0; last = -1;
    for (int i = 0; i < 35; i++) begin
      mh[i] = 8'($urandom); qh[i] = 8'($urandom);
      b8.M = mh[i]; b8.Q = qh[i]; b8.start = 1'b1;
      @(negedge clk);
      if (b8.done) begin
        dn++;
        chk("t6_product", 32'(b8.product), (i >= 8) ? 32'(model8(mh[i-8], qh[i-8])) : 32'hFFFF_FFFF);
        if (last >= 0) chk("t6_spacing", 32'(i - last), 32'd10);
        last = i;
      end
    end
    b8.start = 1'b0;
    chk("t6_done_count", 32'(dn), 32'd3);
    for (int k = 0; k < 20 && b8.busy; k++) @(negedge clk);
    chk("t6_drained", 32'(b8.busy), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
